// File: rtl/gb_mem_pkg.sv
// Shared memory-side definitions: register and OAM addresses, DMA state
// encoding, CPU T-cycle indices and the echo-RAM source fold.
package gb_mem_pkg;

    localparam logic [15:0] REG_DMA  = 16'hFF46;
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam int          OAM_SIZE = 160;

    localparam logic [1:0] T1 = 2'd0;
    localparam logic [1:0] T2 = 2'd1;
    localparam logic [1:0] T3 = 2'd2;
    localparam logic [1:0] T4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    // Pages E0..FF alias work RAM C0..DF, so the source is folded down.
    function automatic logic [7:0] fold_src(input logic [7:0] page);
        if (page >= 8'hE0) begin
            return page - 8'h20;
        end else begin
            return page;
        end
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from {src_hi, 8'h00} into OAM, one
// byte per CPU M-cycle, with strobes registered one clk ahead of their T-cycle.
module oam_dma
    import gb_mem_pkg::*;
#(
    parameter logic [15:0] REG_ADDR        = REG_DMA,
    parameter logic [15:0] DEST_BASE       = OAM_BASE,
    parameter int          LENGTH          = OAM_SIZE,
    parameter int          STARTUP_MCYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [7:0]  dma_data_out,
    output logic        dma_active
);

    localparam logic [7:0] IDX_LAST   = 8'(LENGTH - 1);
    localparam logic [7:0] START_LAST = 8'(STARTUP_MCYCLES - 1);

    dma_state_t  state_r, state_nxt_s;
    logic [7:0]  idx_r, idx_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [15:0] addr_r, addr_nxt_s;
    logic        rd_r, rd_nxt_s;
    logic        wr_r, wr_nxt_s;
    logic [7:0]  latch_r, latch_nxt_s;
    logic [7:0]  src_hi_r, src_hi_nxt_s;
    logic [7:0]  reg_val_r, reg_val_nxt_s;
    logic [1:0]  t_prev_r;
    logic        reg_wr_s;
    logic        mcycle_end_s;

    assign reg_wr_s = cpu_wr && (cpu_addr == REG_ADDR) && (t_cycle == T4);
    // Only the first T4 edge ends an M-cycle, so a CPU halted on T4 does not advance.
    assign mcycle_end_s = (t_cycle == T4) && (t_prev_r != T4);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        cnt_nxt_s     = cnt_r;
        addr_nxt_s    = addr_r;
        rd_nxt_s      = rd_r;
        wr_nxt_s      = wr_r;
        latch_nxt_s   = latch_r;
        src_hi_nxt_s  = src_hi_r;
        reg_val_nxt_s = reg_val_r;

        case (state_r)
            IDLE: begin
                rd_nxt_s = 1'b0;
                wr_nxt_s = 1'b0;
            end
            START: begin
                if (mcycle_end_s && (cnt_r == START_LAST)) begin
                    state_nxt_s = XFER;
                    cnt_nxt_s   = 8'd0;
                    addr_nxt_s  = {src_hi_r, idx_r};
                    rd_nxt_s    = 1'b1;
                    wr_nxt_s    = 1'b0;
                end else if (mcycle_end_s) begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            XFER: begin
                case (t_cycle)
                    T2: begin
                        latch_nxt_s = mem_data_in;
                        addr_nxt_s  = DEST_BASE + {8'd0, idx_r};
                        rd_nxt_s    = 1'b0;
                        wr_nxt_s    = 1'b1;
                    end
                    T4: begin
                        if (mcycle_end_s && (idx_r == IDX_LAST)) begin
                            state_nxt_s = IDLE;
                            idx_nxt_s   = 8'd0;
                            addr_nxt_s  = 16'd0;
                            rd_nxt_s    = 1'b0;
                            wr_nxt_s    = 1'b0;
                        end else if (mcycle_end_s) begin
                            idx_nxt_s  = idx_r + 8'd1;
                            addr_nxt_s = {src_hi_r, idx_r + 8'd1};
                            rd_nxt_s   = 1'b1;
                            wr_nxt_s   = 1'b0;
                        end else begin
                            idx_nxt_s = idx_r;
                        end
                    end
                    default: begin
                        idx_nxt_s = idx_r;
                    end
                endcase
            end
            default: begin
                state_nxt_s = IDLE;
                rd_nxt_s    = 1'b0;
                wr_nxt_s    = 1'b0;
            end
        endcase

        // A register write restarts from any state, including the last-byte edge.
        if (reg_wr_s) begin
            reg_val_nxt_s = cpu_data_in;
            src_hi_nxt_s  = fold_src(cpu_data_in);
            idx_nxt_s     = 8'd0;
            cnt_nxt_s     = 8'd0;
            state_nxt_s   = START;
            addr_nxt_s    = 16'd0;
            rd_nxt_s      = 1'b0;
            wr_nxt_s      = 1'b0;
        end else begin
            reg_val_nxt_s = reg_val_r;
        end
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 8'd0;
            cnt_r     <= 8'd0;
            addr_r    <= 16'd0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            latch_r   <= 8'd0;
            src_hi_r  <= 8'hFF;
            reg_val_r <= 8'hFF;
            t_prev_r  <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            cnt_r     <= cnt_nxt_s;
            addr_r    <= addr_nxt_s;
            rd_r      <= rd_nxt_s;
            wr_r      <= wr_nxt_s;
            latch_r   <= latch_nxt_s;
            src_hi_r  <= src_hi_nxt_s;
            reg_val_r <= reg_val_nxt_s;
            t_prev_r  <= t_cycle;
        end
    end

    // Unselected reads see the open-bus value.
    assign cpu_data_out = (cpu_rd && (cpu_addr == REG_ADDR)) ? reg_val_r : 8'hFF;
    assign dma_addr     = addr_r;
    assign dma_rd       = rd_r;
    assign dma_wr       = wr_r;
    assign dma_data_out = latch_r;
    assign dma_active   = (state_r != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a memory model, a write scoreboard fed by
// the scenario tasks, and per-scenario inline checks.
module tb_oam_dma;
    import gb_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  t_cycle;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic [7:0]  mem_data_in;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic        dma_wr;
    logic [7:0]  dma_data_out;
    logic        dma_active;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_item_t;

    wr_item_t    exp_q[$];
    logic [7:0]  mem [0:65535];
    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_count = 0;
    int          active_clks = 0;
    int          falls = 0;
    logic [15:0] first_rd_addr = 16'd0;
    bit          first_rd_seen = 1'b0;
    logic        freeze = 1'b0;

    oam_dma dut (
        .clk          (clk),
        .rst          (rst),
        .t_cycle      (t_cycle),
        .cpu_addr     (cpu_addr),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .mem_data_in  (mem_data_in),
        .dma_addr     (dma_addr),
        .dma_rd       (dma_rd),
        .dma_wr       (dma_wr),
        .dma_data_out (dma_data_out),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    assign mem_data_in = mem[dma_addr];

    // T-cycle sequencer, can be frozen to model a halted CPU.
    initial begin
        t_cycle = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!freeze) t_cycle = t_cycle + 2'd1;
        end
    end

    // Memory model write port.
    initial begin
        forever begin
            @(posedge clk);
            if (dma_wr) mem[dma_addr] = dma_data_out;
        end
    end

    // Monitor: activity counters and scoreboard pop on each new write.
    initial begin
        logic prev_wr, prev_rd, prev_act;
        wr_item_t item;
        prev_wr = 1'b0; prev_rd = 1'b0; prev_act = 1'b0;
        forever begin
            @(negedge clk);
            if (dma_active === 1'b1) active_clks++;
            if (prev_act && dma_active === 1'b0) falls++;
            if (dma_rd === 1'b1 && !prev_rd && !first_rd_seen) begin
                first_rd_addr = dma_addr;
                first_rd_seen = 1'b1;
            end
            if (dma_wr === 1'b1 && !prev_wr) begin
                wr_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_unexpected: write addr=%h data=%h, required no write", dma_addr, dma_data_out);
                end else begin
                    item = exp_q.pop_front();
                    if (dma_addr !== item.addr || dma_data_out !== item.data)
                        $display("FAIL scoreboard_write: got addr=%h data=%h, required addr=%h data=%h",
                                 dma_addr, dma_data_out, item.addr, item.data);
                    else
                        n_pass++;
                end
            end
            prev_wr  = (dma_wr === 1'b1);
            prev_rd  = (dma_rd === 1'b1);
            prev_act = (dma_active === 1'b1);
        end
    end

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i) ^ 8'h5A;
            1:       return ~8'(i);
            2:       return 8'(i + 3);
            default: return 8'hEE;
        endcase
    endfunction

    task automatic wait_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic load_src(input logic [7:0] hi, input int kind);
        for (int i = 0; i < 256; i++) mem[{hi, 8'h00} + 16'(i)] = pat(kind, i);
    endtask

    task automatic push_exp(input int kind);
        for (int i = 0; i < 160; i++) exp_q.push_back({OAM_BASE + 16'(i), pat(kind, i)});
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 160; i++) mem[OAM_BASE + 16'(i)] = 8'hEE;
    endtask

    task automatic check_oam(input string name, input int kind, input int lo, input int hi);
        int bad;
        bad = 0;
        for (int i = lo; i < hi; i++) if (mem[OAM_BASE + 16'(i)] !== pat(kind, i)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL %s: %0d bad OAM bytes, required 0", name, bad);
        else n_pass++;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) $display("FAIL %s: got %0d, required %0d", name, got, req);
        else n_pass++;
    endtask

    task automatic reset_counters();
        wr_count = 0; active_clks = 0; falls = 0; first_rd_seen = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        int budget;
        budget = 0;
        while (t_cycle !== 2'd3 && budget < 8) begin wait_neg(); budget++; end
        cpu_addr = addr; cpu_data_in = data; cpu_wr = 1'b1;
        wait_neg();
        cpu_wr = 1'b0; cpu_addr = REG_DMA;
    endtask

    task automatic wait_wr(input int n);
        int budget;
        budget = 0;
        while (wr_count < n && budget < 3000) begin wait_neg(); budget++; end
        if (wr_count < n) begin
            n_checks++;
            $display("FAIL wait_wr_timeout: got %0d writes, required %0d", wr_count, n);
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (dma_active === 1'b1 && budget < 3000) begin wait_neg(); budget++; end
        if (dma_active === 1'b1) begin
            n_checks++;
            $display("FAIL wait_done_timeout: dma_active still %b, required 0", dma_active);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) wait_neg();
        check_int("reset_active", int'(dma_active), 0);
        check_int("reset_rd", int'(dma_rd), 0);
        check_int("reset_wr", int'(dma_wr), 0);
        check_int("reset_addr", int'(dma_addr), 0);
        check_int("reset_data_out", int'(dma_data_out), 0);
        check_int("reset_cpu_data_out", int'(cpu_data_out), 8'hFF);
        rst = 1'b0;
        wait_neg();
    endtask

    task automatic test_other_addr();
        reset_counters();
        cpu_write(16'hFF47, 8'hC0);
        repeat (8) wait_neg();
        check_int("other_addr_active_clks", active_clks, 0);
        check_int("other_addr_readback", int'(cpu_data_out), 8'hFF);
    endtask

    task automatic test_basic();
        load_src(8'hC0, 0); clear_oam(); push_exp(0); reset_counters();
        cpu_write(REG_DMA, 8'hC0);
        wait_done();
        check_int("basic_active_clks", active_clks, 644);
        check_int("basic_wr_mcycles", wr_count, 160);
        check_int("basic_first_rd", int'(first_rd_addr), 16'hC000);
        check_oam("basic_oam", 0, 0, 160);
    endtask

    task automatic test_fold();
        load_src(8'hC1, 1); clear_oam(); push_exp(1); reset_counters();
        cpu_write(REG_DMA, 8'hE1);
        check_int("fold_readback", int'(cpu_data_out), 8'hE1);
        wait_done();
        check_int("fold_first_rd", int'(first_rd_addr), 16'hC100);
        check_oam("fold_oam", 1, 0, 160);
    endtask

    task automatic test_restart();
        load_src(8'hC0, 0); load_src(8'hD0, 2); clear_oam(); push_exp(0); reset_counters();
        cpu_write(REG_DMA, 8'hC0);
        wait_wr(51);
        exp_q.delete();
        push_exp(2);
        cpu_write(REG_DMA, 8'hD0);
        wait_done();
        check_int("restart_falls", falls, 1);
        check_int("restart_active_clks", active_clks, 852);
        check_int("restart_wr_mcycles", wr_count, 211);
        check_oam("restart_oam", 2, 0, 160);
    endtask

    task automatic test_rst_mid();
        load_src(8'hC0, 0); clear_oam(); push_exp(0); reset_counters();
        cpu_write(REG_DMA, 8'hC0);
        wait_wr(80);
        rst = 1'b1;
        wait_neg();
        check_int("rst_mid_active", int'(dma_active), 0);
        check_int("rst_mid_wr", int'(dma_wr), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (8) wait_neg();
        check_oam("rst_mid_head", 0, 0, 80);
        check_oam("rst_mid_untouched", 3, 80, 160);
        check_int("rst_mid_readback", int'(cpu_data_out), 8'hFF);
    endtask

    task automatic test_back_to_back();
        load_src(8'hC0, 0); clear_oam(); push_exp(0); push_exp(0); reset_counters();
        cpu_write(REG_DMA, 8'hC0);
        wait_wr(160);
        cpu_write(REG_DMA, 8'hC0);
        wait_done();
        check_int("b2b_falls", falls, 1);
        check_int("b2b_active_clks", active_clks, 1288);
        check_int("b2b_wr_mcycles", wr_count, 320);
        check_int("b2b_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_freeze();
        load_src(8'hC0, 0); clear_oam(); push_exp(0); reset_counters();
        cpu_write(REG_DMA, 8'hC0);
        wait_wr(30);
        freeze = 1'b1;
        repeat (10) wait_neg();
        check_int("freeze_addr", int'(dma_addr), 16'hFE1D);
        check_int("freeze_wr", int'(dma_wr), 1);
        check_int("freeze_tcycle", int'(t_cycle), 2);
        check_int("freeze_wr_count", wr_count, 30);
        freeze = 1'b0;
        wait_done();
        check_int("freeze_active_clks", active_clks, 654);
        check_int("freeze_wr_mcycles", wr_count, 160);
        check_oam("freeze_oam", 0, 0, 160);
    endtask

    initial begin
        rst = 1'b1; cpu_addr = REG_DMA; cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_data_in = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_other_addr();
        test_basic();
        test_fold();
        test_restart();
        test_rst_mid();
        test_back_to_back();
        test_freeze();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine on the memory side of the CPU address mux.
- A CPU write to the DMA register starts a copy of 160 bytes from {src_hi, 8'h00} into OAM at 16'hFE00.
- While a copy is running, it drives mem_ctrl_sel=1 and supplies the DMA address, read and write strobes, and write data to the memory model.
- It runs in lock-step with the CPU M-cycle timing (t_cycle) so that one byte moves per M-cycle.

Parameters:
- REG_ADDR, 16'hFF46, CPU address of the DMA start/source register.
- DEST_BASE, 16'hFE00, OAM base address.
- LENGTH, 160, bytes per transfer (must be 1..256).
- STARTUP_MCYCLES, 1, idle M-cycles between the register write and the first byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- t_cycle  in  2  CPU T-cycle index 0..3, from decode
- cpu_addr  in  16  CPU address bus (buffered)
- cpu_wr  in  1  CPU write strobe
- cpu_rd  in  1  CPU read strobe
- cpu_data_in  in  8  CPU write data
- cpu_data_out  out  8  register readback, valid when cpu_rd and cpu_addr==REG_ADDR
- mem_data_in  in  8  memory read data (mem_data_out of the memory model)
- dma_addr  out  16  DMA address into the memory address mux
- dma_rd  out  1  DMA read strobe
- dma_wr  out  1  DMA write strobe
- dma_data_out  out  8  DMA write data
- dma_active  out  1  drives mem_ctrl_sel; high in START and XFER

Behaviour:
- Reset (rst sampled high on a clk edge):
  - state=IDLE, idx=0, src_hi=8'hFF, latch=0.
  - Outputs: dma_addr=0, dma_rd=0, dma_wr=0, dma_data_out=0, dma_active=0, cpu_data_out=8'hFF.
- Register write:
  - Occurs on a clk edge with cpu_wr=1, cpu_addr==REG_ADDR and t_cycle==3.
  - Stores reg_val=cpu_data_in.
  - Loads src_hi = (cpu_data_in >= 8'hE0) ? cpu_data_in - 8'h20 : cpu_data_in (echo-RAM fold).
  - Sets idx=0 and state=START.
  - Applies in any state, so a write during XFER restarts from the new base.
- Readback: cpu_data_out=reg_val combinationally, i.e. the last written value, not the folded one.
- START:
  - Counts STARTUP_MCYCLES complete M-cycles, each ending on the edge with t_cycle==3.
  - Then goes to XFER.
  - No strobes are asserted.
- XFER, one byte per M-cycle:
  - t_cycle 0..1: dma_addr={src_hi, idx}, dma_rd=1, dma_wr=0.
  - Edge with t_cycle==1: latch<=mem_data_in.
  - t_cycle 2..3: dma_addr=DEST_BASE+idx, dma_wr=1, dma_rd=0, dma_data_out=latch.
  - Edge with t_cycle==3: if idx==LENGTH-1, go to IDLE; otherwise idx<=idx+1.
- Strobes and dma_addr are registered. They change only on clk edges, one clk ahead of the t_cycle they serve.
- Latency:
  - First source read occurs in the (STARTUP_MCYCLES+1)-th M-cycle after the register write.
  - Total active duration = (STARTUP_MCYCLES+LENGTH) M-cycles = 644 clks at defaults.
- dma_active:
  - Rises on the clk edge of the register write.
  - Falls on the edge that ends the last byte's t_cycle==3.
- Boundaries:
  - idx is 8 bits and never wraps past LENGTH-1.
  - Source address = {src_hi, idx}, so there is no carry into src_hi.
  - Register write and the last-byte edge in the same clk: the restart wins (START, idx=0).
  - rst during START/XFER: IDLE at the next edge, with no partial write strobe after that edge.
  - t_cycle held constant (CPU halted): state and idx hold. Strobes stay as registered.
  - cpu_rd/cpu_wr to other addresses: ignored.
  - The block does not arbitrate CPU accesses. The top-level mux gives the bus to DMA while dma_active is high.

Decomposition:
- Shared package gb_mem_pkg holds:
  - REG_DMA (16'hFF46), OAM_BASE (16'hFE00), OAM_SIZE (160).
  - The dma_state_t enum {IDLE, START, XFER}.
  - T-cycle constants T1..T4 = 2'd0..2'd3.
- No sub-module. This is a single FSM with a counter; the M-cycle boundary detect is inline.

Test Plan:
- Write 8'hC0 to FF46, memory C000..C09F = i^8'h5A:
  - FE00..FE9F equal i^8'h5A.
  - dma_active high for exactly 644 clks.
  - Exactly 160 dma_wr M-cycles.
- Write 8'hE1:
  - First dma_rd address is 16'hC100.
  - cpu_data_out reads 8'hE1.
- Write 8'hC0, then write 8'hD0 at byte 50:
  - idx resets to 0 and the copy continues from D000.
  - FE00..FE9F hold D000..D09F data.
  - dma_active stays high continuously.
- Assert rst at byte 80:
  - Next edge: dma_active=0, dma_wr=0.
  - FE50.. untouched, cpu_data_out=8'hFF.
- Write 8'hC0 on the same edge as the last byte of a prior transfer:
  - State goes to START and a full new transfer follows.
  - dma_active never drops.
- Freeze t_cycle at 2 for 10 clks mid-transfer:
  - idx and dma_addr hold.
  - The transfer resumes and completes correctly.
